// File: rtl/button_inc_pulse.sv
// ============================================================================
// button_inc_pulse: synchronizes and debounces a push-button, emitting one
// INC strobe per press with optional auto-repeat while held.
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_inc_pulse #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SW,
  output logic INC,
  output logic PRESSED
);

  localparam int c_DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_RP_W   = (c_RP_MAX > 1) ? $clog2(c_RP_MAX) : 1;

  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_RP_W-1:0] c_RD_LAST = c_RP_W'(REPEAT_DELAY - 1);
  localparam logic [c_RP_W-1:0] c_RP_LAST = c_RP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic              r_sync1;
  logic              r_sw_s;
  logic              r_stable;
  logic [c_DB_W-1:0] r_db_cnt;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_RP_W-1:0] r_rp_cnt;
  logic [c_RP_W-1:0] w_rp_nxt;
  logic              r_inc;
  logic              w_inc_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 1'b0;
      r_sw_s  <= 1'b0;
    end else begin
      r_sync1 <= SW;
      r_sw_s  <= r_sync1;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing edges.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stable <= 1'b0;
      r_db_cnt <= '0;
    end else if (r_sw_s != r_stable) begin
      if (r_db_cnt == c_DB_LAST) begin
        r_stable <= r_sw_s;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= ST_IDLE;
      r_rp_cnt <= '0;
      r_inc    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rp_cnt <= w_rp_nxt;
      r_inc    <= w_inc_nxt;
    end
  end

  // Release is tested first so it always wins over a timer expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_rp_nxt    = r_rp_cnt;
    w_inc_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_stable) begin
          w_inc_nxt   = 1'b1;
          w_rp_nxt    = '0;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!r_stable) begin
          w_state_nxt = ST_IDLE;
        end else if (REPEAT_EN && (r_rp_cnt == c_RD_LAST)) begin
          w_inc_nxt   = 1'b1;
          w_rp_nxt    = '0;
          w_state_nxt = ST_REPEAT;
        end else if (REPEAT_EN) begin
          w_rp_nxt = r_rp_cnt + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!r_stable) begin
          w_state_nxt = ST_IDLE;
        end else if (r_rp_cnt == c_RP_LAST) begin
          w_inc_nxt = 1'b1;
          w_rp_nxt  = '0;
        end else begin
          w_rp_nxt = r_rp_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign INC     = r_inc;
  assign PRESSED = r_stable;

endmodule

`default_nettype wire

// File: tb/tb_button_inc_pulse.sv
// Bench for button_inc_pulse: table-driven clean press, hand-written corner
// sequences and a randomized run against a history-window reference model.
`default_nettype none

module tb_button_inc_pulse;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  typedef int iq_t[$];
  typedef struct {
    bit sw;
    bit inc;
    bit pressed;
  } vec_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic SW = 1'b0;
  logic inc_a, pr_a, inc_b, pr_b;

  int n_vec = 0;
  int n_err = 0;
  int edge_no = 0;
  iq_t inc_log, inc_log_b;

  // reference model state
  bit m_sync1, m_sws, m_stable, m_act, m_inc_a, m_inc_b;
  bit m_hist[$];
  int m_k;

  button_inc_pulse #(.DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .CLK(CLK), .RST_N(RST_N), .SW(SW), .INC(inc_a), .PRESSED(pr_a));

  button_inc_pulse #(.DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_nr (
    .CLK(CLK), .RST_N(RST_N), .SW(SW), .INC(inc_b), .PRESSED(pr_b));

  always #5 CLK = ~CLK;

  function automatic void model_reset();
    m_sync1 = 1'b0; m_sws = 1'b0; m_stable = 1'b0; m_act = 1'b0;
    m_inc_a = 1'b0; m_inc_b = 1'b0; m_k = 0;
    m_hist.delete();
  endfunction

  // Level flips once the last DB synchronized samples all disagree with it;
  // pulses land at press offsets 0, RD, RD+RP, RD+2RP, ...
  function automatic void model_edge(bit sw_now);
    bit old_st;
    bit all_diff;
    old_st = m_stable;
    m_hist.push_back(m_sws);
    if (m_hist.size() > DB) void'(m_hist.pop_front());
    all_diff = (m_hist.size() == DB);
    foreach (m_hist[i]) if (m_hist[i] == old_st) all_diff = 1'b0;
    if (all_diff) m_stable = ~old_st;
    m_inc_a = 1'b0;
    m_inc_b = 1'b0;
    if (!old_st) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      m_act = 1'b1; m_k = 0; m_inc_a = 1'b1; m_inc_b = 1'b1;
    end else begin
      m_k++;
      if (m_k == RD || (m_k > RD && (m_k - RD) % RP == 0)) m_inc_a = 1'b1;
    end
    m_sws = m_sync1;
    m_sync1 = sw_now;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, edge_no, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input iq_t got, input iq_t exp);
    chk_int({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk_int({name, "_edge"}, got[i], exp[i]);
  endtask

  task automatic step(input bit sw_v);
    @(negedge CLK);
    SW = sw_v;
    @(posedge CLK);
    edge_no++;
    if (RST_N) model_edge(sw_v);
    #1;
    chk("inc_rep", inc_a, m_inc_a);
    chk("inc_norep", inc_b, m_inc_b);
    chk("pressed", pr_a, m_stable);
    chk("pressed_nr", pr_b, m_stable);
    if (inc_a) inc_log.push_back(edge_no);
    if (inc_b) inc_log_b.push_back(edge_no);
  endtask

  task automatic new_seq();
    edge_no = 0;
    inc_log.delete();
    inc_log_b.delete();
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  initial begin
    vec_t tbl[16];
    iq_t exp_q;
    int j, late, run;
    bit lvl;

    for (int e = 1; e <= 16; e++)
      tbl[e-1] = '{sw: (e <= 8), inc: (e == 7), pressed: (e >= 6 && e <= 13)};

    model_reset();
    RST_N = 1'b0;
    SW = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_inc", inc_a, 1'b0);
    chk("reset_pressed", pr_a, 1'b0);
    @(posedge CLK);
    #2 RST_N = 1'b1;

    // clean press
    new_seq();
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].sw);
      chk("tbl_inc", inc_a, tbl[i].inc);
      chk("tbl_pressed", pr_a, tbl[i].pressed);
    end
    chk_int("clean_inc_total", inc_log.size(), 1);

    // bounce rejection: steady high starts at edge 8
    new_seq();
    step(1); step(1); step(1); step(0); step(1); step(1); step(0);
    hold(1, 9);
    hold(0, 10);
    exp_q = '{14};
    chk_log("bounce", inc_log, exp_q);

    // auto-repeat, plus the no-repeat instance in parallel
    new_seq();
    hold(1, 40);
    hold(0, 14);
    exp_q = '{7, 17, 22, 27, 32, 37};
    j = 0;
    late = 0;
    foreach (inc_log[i]) begin
      if (inc_log[i] <= 40) begin
        if (j < 6) chk_int("repeat_edge", inc_log[i], exp_q[j]);
        j++;
      end else if (inc_log[i] >= 47) begin
        late++;
      end
    end
    chk_int("repeat_count_in_hold", j, 6);
    chk_int("repeat_after_release", late, 0);
    exp_q = '{7};
    chk_log("norepeat", inc_log_b, exp_q);

    // release lands on the delay expiry edge (17); next press still pulses once
    new_seq();
    hold(1, 10);
    hold(0, 10);
    hold(1, 10);
    hold(0, 12);
    exp_q = '{7, 27};
    chk_log("release_on_expiry", inc_log, exp_q);

    // reset mid-hold, right after a repeat pulse
    new_seq();
    hold(1, 22);
    chk("pre_reset_inc", inc_a, 1'b1);
    #1 RST_N = 1'b0;
    #1;
    chk("rst_async_inc", inc_a, 1'b0);
    chk("rst_async_pressed", pr_a, 1'b0);
    chk("rst_async_pressed_nr", pr_b, 1'b0);
    model_reset();
    @(posedge CLK);
    @(posedge CLK);
    #2 RST_N = 1'b1;
    new_seq();
    hold(1, 25);
    exp_q = '{7, 17, 22};
    chk_log("post_reset", inc_log, exp_q);
    exp_q = '{7};
    chk_log("post_reset_nr", inc_log_b, exp_q);
    hold(0, 12);

    // randomized runs with occasional asynchronous resets
    lvl = 1'b0;
    for (int r = 0; r < 120; r++) begin
      lvl = ~lvl;
      run = $urandom_range(1, 25);
      for (int i = 0; i < run; i++) begin
        step(lvl);
        if ($urandom_range(0, 199) == 0) begin
          #2 RST_N = 1'b0;
          #1;
          chk("rnd_rst_inc", inc_a, 1'b0);
          chk("rnd_rst_pressed", pr_a, 1'b0);
          model_reset();
          @(posedge CLK);
          #2 RST_N = 1'b1;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
